gmm_match_pipe_k: RTL
=====================

Name:
gmm_match_pipe_k

Overview:
- Parametrised successor of the GMM three-cluster distance/match pipeline inside the GMM foreground detector, between cluster-memory readout and the model-update stage.
- For every pixel beat it computes a per-cluster colour distance (squared-L2 or L1, selected per beat) against K cluster means.
- It compares each distance with a per-cluster limit (coef × variance) and produces a match mask, the best-matching cluster (argmin), and the farthest cluster (argmax).
- It is a 4-stage valid/ready pipeline with a full-rate, lossless stall path.

Parameters:
- K, 3, number of clusters per pixel (1..8)
- C, 3, colour channels per pixel (1..4)
- CW, 8, bits per colour channel
- VW, 16, bits per stored cluster variance
- COEF_W, 5, bits of the variance-limit coefficient
- DW, 20, distance width; must be at least 2*CW+$clog2(C)+1, otherwise elaboration fails
- TAG_W, 32, width of the opaque passthrough sideband
- IW, $clog2(K) (min 1), localparam, cluster index width
- NW, $clog2(K+1), localparam, active-cluster-count width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset (asserted when rst=0)
- snk_valid  in  1  input beat valid
- snk_ready  out  1  input beat accepted when snk_valid && snk_ready
- snk_pix  in  C*CW  incoming pixel colour, channel 0 in the LSBs
- snk_mean  in  K*C*CW  cluster means, cluster k at [k*C*CW +: C*CW]
- snk_var  in  K*VW  cluster variances
- snk_n  in  NW  number of active clusters; values above K are clamped to K
- snk_coef  in  COEF_W  variance-limit coefficient, sampled with the beat
- snk_mode  in  1  0 = squared-L2 metric, 1 = L1 metric, sampled with the beat
- snk_tag  in  TAG_W  sideband carried through unchanged
- src_ready  in  1  downstream ready
- src_valid  out  1  output beat valid
- src_dist  out  K*DW  per-cluster distance
- src_mask  out  K  bit k = (k < n) && dist[k] <= lim[k]
- src_min  out  DW  distance of the best-matching cluster
- src_min_idx  out  IW  index of the best-matching cluster
- src_max  out  DW  largest distance among active clusters
- src_max_idx  out  IW  index of that largest distance
- src_matched  out  1  OR-reduction of src_mask
- src_tag  out  TAG_W  sideband associated with the beat

Behaviour:
- Reset: all stage valids and src_valid are 0; every src_* data output is 0; in-flight beats are discarded. Asserting reset mid-stream has the same effect. After release the first beat is accepted on the first clock edge with snk_valid=1.
- Handshake: each stage i holds valid_i. ready_i = ready_{i+1} | ~valid_i, with ready_4 = src_ready, and snk_ready = ready_1.
  - A stage loads only when it is ready and the stage before it is valid.
  - valid_i clears only when the stage is ready and the stage before it is empty. This corrects the earlier behaviour, which set valid on upstream-valid regardless of ready.
  - src_* are held stable while src_valid && !src_ready.
  - No combinational path from snk_valid to src_*. snk_ready depends combinationally only on the stage valids and src_ready.
- Latency and throughput: 4 cycles from acceptance to src_valid. One beat per cycle when src_ready is held at 1. The pipeline holds at most 4 beats. Order is always preserved.
- S1:
  - Per cluster and channel, a[k][c] = |pix[c] - mean[k][c]| (CW bits).
  - lim[k] = coef × var[k], computed at COEF_W+VW bits.
  - Register mode, clamped n, and tag.
- S2: dist[k] = 1 + Σc a² when mode=0, or 1 + Σc a when mode=1. Zero-extend to DW; no saturation is needed given the DW constraint.
- S3:
  - mask[k] = (k < n) && (dist[k] ≤ lim[k]); compare zero-extended to max(DW, COEF_W+VW).
  - Argmin over masked clusters: smallest dist wins; ties go to the lowest index.
  - If the mask is 0: min = dist[0], min_idx = 0.
  - Argmax over k < n: largest dist wins; ties go to the lowest index.
  - If n = 0: max = dist[0], max_idx = 0, and mask = 0.
- S4: register all results; src_matched = |mask.
- src_dist entries for k ≥ n are still computed and output, but they never affect mask, min, or max.
- snk_coef and snk_mode travel with their own beat; changing them between beats affects only later beats.

Test Plan:
- Basic L2 case. Setup: K=3, C=3, pix=(100,100,100), means (100,100,100) / (103,104,100) / (0,0,0), var=10 each, coef=5 (lim=50), n=3, mode=0. Expected: dist = 1 / 26 / 30001; mask = 3'b011; min = 1, idx 0; max = 30001, idx 2; matched = 1; 4 cycles after acceptance.
- L1 mode. Same beat with mode=1. Expected: dist = 1 / 8 / 301; mask = 3'b011; max_idx = 2.
- Tie and active-count handling:
  - Dists 26 / 26 / 26 with lim 20 / 50 / 50 → mask = 3'b110, min_idx = 1, max_idx = 0.
  - Same beat with n=2 → mask = 3'b010, min_idx = 1.
  - Same beat with n=0 → mask = 0, matched = 0, min_idx = 0, max_idx = 0.
- Backpressure. 100 back-to-back beats with incrementing tag; src_ready randomly low ~40% of cycles, including a 10-cycle run low.
  - During the run, snk_ready falls after 4 beats are held.
  - src_* stay stable while stalled.
  - All 100 tags emerge exactly once, in order.
  - With src_ready=1 throughout, output is one beat per cycle.
- Reset mid-stream. Drop rst to 0 with 3 beats in flight. Expected: src_valid and all outputs go to 0 immediately. After release, the next beat emerges 4 cycles after acceptance and no stale tag appears.
- Extremes. pix = 255s, means = 0s, C=3, mode=0 → dist = 195076 with no overflow. Coef = 31, var = 65535 → lim = 2031585, so the cluster matches.

Source files
------------

// File: rtl/gmm_match_pipe_k_if.sv
// Beat interface of the GMM distance/match pipeline: sink side carries one pixel
// with its K cluster records, source side carries the per-cluster match results.
interface gmm_match_pipe_k_if #(
  parameter int K      = 3,
  parameter int C      = 3,
  parameter int CW     = 8,
  parameter int VW     = 16,
  parameter int COEF_W = 5,
  parameter int DW     = 20,
  parameter int TAG_W  = 32
);
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam int NW = $clog2(K + 1);

  logic                  snk_valid;
  logic                  snk_ready;
  logic [C*CW-1:0]       snk_pix;
  logic [K*C*CW-1:0]     snk_mean;
  logic [K*VW-1:0]       snk_var;
  logic [NW-1:0]         snk_n;
  logic [COEF_W-1:0]     snk_coef;
  logic                  snk_mode;
  logic [TAG_W-1:0]      snk_tag;

  logic                  src_ready;
  logic                  src_valid;
  logic [K*DW-1:0]       src_dist;
  logic [K-1:0]          src_mask;
  logic [DW-1:0]         src_min;
  logic [IW-1:0]         src_min_idx;
  logic [DW-1:0]         src_max;
  logic [IW-1:0]         src_max_idx;
  logic                  src_matched;
  logic [TAG_W-1:0]      src_tag;

  modport master (
    output snk_valid, snk_pix, snk_mean, snk_var, snk_n, snk_coef, snk_mode, snk_tag,
    output src_ready,
    input  snk_ready,
    input  src_valid, src_dist, src_mask, src_min, src_min_idx, src_max, src_max_idx,
    input  src_matched, src_tag
  );

  modport slave (
    input  snk_valid, snk_pix, snk_mean, snk_var, snk_n, snk_coef, snk_mode, snk_tag,
    input  src_ready,
    output snk_ready,
    output src_valid, src_dist, src_mask, src_min, src_min_idx, src_max, src_max_idx,
    output src_matched, src_tag
  );
endinterface

// File: rtl/gmm_match_pipe_k.sv
// Four-stage valid/ready pipeline: per-cluster colour distance (L2^2 or L1),
// variance-limit match mask, argmin over matches and argmax over active clusters.
module gmm_match_pipe_k #(
  parameter int K      = 3,
  parameter int C      = 3,
  parameter int CW     = 8,
  parameter int VW     = 16,
  parameter int COEF_W = 5,
  parameter int DW     = 20,
  parameter int TAG_W  = 32
) (
  input logic              clk,
  input logic              rst,
  gmm_match_pipe_k_if.slave bus
);
  localparam int IW   = (K > 1) ? $clog2(K) : 1;
  localparam int NW   = $clog2(K + 1);
  localparam int LW   = COEF_W + VW;
  localparam int CMPW = (DW > LW) ? DW : LW;

  if (DW < 2*CW + $clog2(C) + 1) begin : g_dw_check
    $error("gmm_match_pipe_k: DW too narrow for the distance sum");
  end

  logic v1, v2, v3, v4;
  logic r1, r2, r3, r4;

  // A stage can take a new beat when it is empty or its contents move on this edge.
  assign r4 = bus.src_ready | ~v4;
  assign r3 = r4 | ~v3;
  assign r2 = r3 | ~v2;
  assign r1 = r2 | ~v1;
  assign bus.snk_ready = r1;

  logic [K-1:0][C-1:0][CW-1:0] a_c, s1_a;
  logic [K-1:0][LW-1:0]        lim_c, s1_lim, s2_lim;
  logic [NW-1:0]               n_c, s1_n, s2_n;
  logic                        s1_mode;
  logic [TAG_W-1:0]            s1_tag, s2_tag, s3_tag, s4_tag;

  logic [K-1:0][DW-1:0]        dist_c, s2_dist, s3_dist, s4_dist;
  logic [K-1:0]                mask_c, s3_mask, s4_mask;
  logic [DW-1:0]               min_c, s3_min, s4_min;
  logic [DW-1:0]               max_c, s3_max, s4_max;
  logic [IW-1:0]               min_idx_c, s3_min_idx, s4_min_idx;
  logic [IW-1:0]               max_idx_c, s3_max_idx, s4_max_idx;
  logic                        have_min;

  always_comb begin
    a_c   = '0;
    lim_c = '0;
    for (int unsigned k = 0; k < K; k++) begin
      lim_c[k] = LW'(bus.snk_coef) * LW'(bus.snk_var[k*VW +: VW]);
      for (int unsigned c = 0; c < C; c++) begin
        a_c[k][c] = (bus.snk_pix[c*CW +: CW] > bus.snk_mean[(k*C + c)*CW +: CW])
                  ? bus.snk_pix[c*CW +: CW] - bus.snk_mean[(k*C + c)*CW +: CW]
                  : bus.snk_mean[(k*C + c)*CW +: CW] - bus.snk_pix[c*CW +: CW];
      end
    end
    n_c = (bus.snk_n > NW'(K)) ? NW'(K) : bus.snk_n;
  end

  always_comb begin
    dist_c = '0;
    for (int unsigned k = 0; k < K; k++) begin
      dist_c[k] = DW'(1);
      for (int unsigned c = 0; c < C; c++) begin
        dist_c[k] = dist_c[k] + (s1_mode ? DW'(s1_a[k][c])
                                         : DW'(s1_a[k][c]) * DW'(s1_a[k][c]));
      end
    end
  end

  // Strict comparisons keep the lowest index on ties; dist[0]/index 0 are the fallbacks.
  always_comb begin
    mask_c    = '0;
    min_c     = s2_dist[0];
    min_idx_c = '0;
    max_c     = s2_dist[0];
    max_idx_c = '0;
    have_min  = 1'b0;
    for (int unsigned k = 0; k < K; k++) begin
      if (NW'(k) < s2_n) begin
        if (s2_dist[k] > max_c) begin
          max_c     = s2_dist[k];
          max_idx_c = IW'(k);
        end
        if (CMPW'(s2_dist[k]) <= CMPW'(s2_lim[k])) begin
          mask_c[k] = 1'b1;
          if (!have_min || s2_dist[k] < min_c) begin
            min_c     = s2_dist[k];
            min_idx_c = IW'(k);
            have_min  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; v4 <= 1'b0;
      s1_a <= '0; s1_lim <= '0; s1_n <= '0; s1_mode <= 1'b0; s1_tag <= '0;
      s2_dist <= '0; s2_lim <= '0; s2_n <= '0; s2_tag <= '0;
      s3_dist <= '0; s3_mask <= '0; s3_min <= '0; s3_min_idx <= '0;
      s3_max <= '0; s3_max_idx <= '0; s3_tag <= '0;
      s4_dist <= '0; s4_mask <= '0; s4_min <= '0; s4_min_idx <= '0;
      s4_max <= '0; s4_max_idx <= '0; s4_tag <= '0;
    end else begin
      if (r1) begin
        v1 <= bus.snk_valid;
        if (bus.snk_valid) begin
          s1_a    <= a_c;
          s1_lim  <= lim_c;
          s1_n    <= n_c;
          s1_mode <= bus.snk_mode;
          s1_tag  <= bus.snk_tag;
        end
      end
      if (r2) begin
        v2 <= v1;
        if (v1) begin
          s2_dist <= dist_c;
          s2_lim  <= s1_lim;
          s2_n    <= s1_n;
          s2_tag  <= s1_tag;
        end
      end
      if (r3) begin
        v3 <= v2;
        if (v2) begin
          s3_dist    <= s2_dist;
          s3_mask    <= mask_c;
          s3_min     <= min_c;
          s3_min_idx <= min_idx_c;
          s3_max     <= max_c;
          s3_max_idx <= max_idx_c;
          s3_tag     <= s2_tag;
        end
      end
      if (r4) begin
        v4 <= v3;
        if (v3) begin
          s4_dist    <= s3_dist;
          s4_mask    <= s3_mask;
          s4_min     <= s3_min;
          s4_min_idx <= s3_min_idx;
          s4_max     <= s3_max;
          s4_max_idx <= s3_max_idx;
          s4_tag     <= s3_tag;
        end
      end
    end
  end

  assign bus.src_valid   = v4;
  assign bus.src_dist    = s4_dist;
  assign bus.src_mask    = s4_mask;
  assign bus.src_min     = s4_min;
  assign bus.src_min_idx = s4_min_idx;
  assign bus.src_max     = s4_max;
  assign bus.src_max_idx = s4_max_idx;
  assign bus.src_matched = |s4_mask;
  assign bus.src_tag     = s4_tag;
endmodule
